// File: rtl/counter_sweep_pkg.sv
// Shared types for the triangle-sweep controller and its counter datapath.
package counter_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } sweep_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_load_counter.sv
// Up/down counter with synchronous parallel load; load has priority over en.
module updown_load_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en) begin
      count_q <= dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sequences the up/down counter through lo->hi->lo triangles, num_cycles times.
// Handshake: start is accepted only in IDLE; done pulses one cycle on completion.
module counter_sweep_ctrl
  import counter_sweep_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CYC_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [CYC_W-1:0] num_cycles,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             dir_out,
  output logic [WIDTH-1:0] count_out
);

  sweep_state_t     state_q, state_d;
  logic             dir_q, dir_d;
  logic             cfg_err_q, cfg_err_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [CYC_W-1:0] ncyc_q, ncyc_d, cyc_q, cyc_d;

  logic             cnt_en, cnt_load, cnt_dir;
  logic [WIDTH-1:0] cnt_load_val, count;
  logic [CYC_W:0]   cyc_next;
  logic             last_cycle;

  // One extra bit so the completed-cycle compare cannot overflow.
  assign cyc_next   = {1'b0, cyc_q} + {{CYC_W{1'b0}}, 1'b1};
  assign last_cycle = cyc_next >= {1'b0, ncyc_q};

  updown_load_counter #(.WIDTH(WIDTH)) u_counter (
    .clk      (clk),
    .rstn     (rstn),
    .en       (cnt_en),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dir      (cnt_dir),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      dir_q     <= DIR_UP;
      cfg_err_q <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      ncyc_q    <= '0;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      cfg_err_q <= cfg_err_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      ncyc_q    <= ncyc_d;
      cyc_q     <= cyc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    cfg_err_d    = 1'b0;
    lo_d         = lo_q;
    hi_d         = hi_q;
    ncyc_d       = ncyc_q;
    cyc_d        = cyc_q;
    cnt_en       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = lo_q;
    cnt_dir      = dir_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (lo >= hi || num_cycles == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            lo_d         = lo;
            hi_d         = hi;
            ncyc_d       = num_cycles;
            cyc_d        = '0;
            cnt_load     = 1'b1;
            cnt_load_val = lo;
            state_d      = UP;
            dir_d        = DIR_UP;
          end
        end
      end
      UP: begin
        if (abort) begin
          state_d = IDLE;
          dir_d   = DIR_UP;
        end else if (!hold) begin
          if (count == hi_q) begin
            cnt_load     = 1'b1;
            cnt_load_val = hi_q - WIDTH'(1);
            state_d      = DOWN;
            dir_d        = DIR_DOWN;
          end else begin
            cnt_en  = 1'b1;
            cnt_dir = DIR_UP;
          end
        end
      end
      DOWN: begin
        if (abort) begin
          state_d = IDLE;
          dir_d   = DIR_UP;
        end else if (!hold) begin
          if (count == lo_q) begin
            if (last_cycle) begin
              state_d = DONE;
            end else begin
              // Restart the rise at lo+1 so the shared lo is not repeated.
              cnt_load     = 1'b1;
              cnt_load_val = lo_q + WIDTH'(1);
              state_d      = UP;
              dir_d        = DIR_UP;
              cyc_d        = cyc_next[CYC_W-1:0];
            end
          end else begin
            cnt_en  = 1'b1;
            cnt_dir = DIR_DOWN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        dir_d   = DIR_UP;
      end
      default: begin
        state_d = IDLE;
        dir_d   = DIR_UP;
      end
    endcase
  end

  assign busy      = (state_q == UP) || (state_q == DOWN);
  assign done      = (state_q == DONE);
  assign cfg_err   = cfg_err_q;
  assign dir_out   = dir_q;
  assign count_out = count;

endmodule
